// File: rtl/pent_dram_seq.sv
// Pentagon DRAM cycle sequencer: divides CLK into 8-phase slots, arbitrates each slot
// between video, CPU, refresh and idle, and drives registered RAS/CAS/AMUX/WE and latch strobes.
module pent_dram_seq #(
  parameter int REF_PERIOD = 64
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       VID_REQ,
  input  logic       MREQ_n,
  input  logic       RFSH_n,
  input  logic       WR_n,
  input  logic       A15,
  input  logic       A14,
  output logic       RAS_n,
  output logic       CAS_n,
  output logic       AMUX,
  output logic       WE_n,
  output logic       VID_LE,
  output logic       CPU_LE,
  output logic       CPU_SLOT,
  output logic       REF_SLOT,
  output logic       CPU_MISS,
  output logic [2:0] PHASE
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_VID  = 2'd1;
  localparam logic [1:0] S_CPU  = 2'd2;
  localparam logic [1:0] S_REF  = 2'd3;
  localparam logic [7:0] REF_MAX = 8'(REF_PERIOD);
  localparam logic [7:0] STROBES_OFF = 8'b1101_0000;

  logic [1:0] slot, nslot, dec;
  logic [2:0] nphase;
  logic [7:0] ref_cnt;
  logic       cpu_pend, wr_pend, arm, z80_ref_pend, slot_wr, nwr;
  logic       last, cpu_set, ref_set, forced, cpu_start, ref_start;

  // Packed strobe set for slot type s at phase p: {RAS_n,CAS_n,AMUX,WE_n,VID_LE,CPU_LE,CPU_SLOT,REF_SLOT}
  function automatic logic [7:0] strobes(input logic [1:0] s, input logic [2:0] p, input logic wr);
    logic ras, cas, amux, we, vle, cle;
    logic p16, p26, p36, p15;
    p16 = (p >= 3'd1) && (p <= 3'd6);
    p26 = (p >= 3'd2) && (p <= 3'd6);
    p36 = (p >= 3'd3) && (p <= 3'd6);
    p15 = (p >= 3'd1) && (p <= 3'd5);
    ras = 1'b1; cas = 1'b1; amux = 1'b0; we = 1'b1; vle = 1'b0; cle = 1'b0;
    case (s)
      S_VID, S_CPU: begin
        ras  = !p16;
        amux = p26;
        cas  = !p36;
        vle  = (s == S_VID) && (p == 3'd5);
        cle  = (s == S_CPU) && wr && (p == 3'd5);
        we   = !((s == S_CPU) && !wr && p26);
      end
      S_REF: begin
        // CAS-before-RAS refresh
        cas = !p15;
        ras = !p26;
      end
      default: ;
    endcase
    return {ras, cas, amux, we, vle, cle, (s == S_CPU), (s == S_REF)};
  endfunction

  always_comb begin
    last    = (PHASE == 3'd7);
    nphase  = PHASE + 3'd1;
    // arm blocks re-arming while the Z80 still holds MREQ_n from a served access
    cpu_set = !MREQ_n && RFSH_n && (A15 || A14) && arm;
    ref_set = !MREQ_n && !RFSH_n;
    forced  = (ref_cnt == REF_MAX);
    if (forced)                      dec = S_REF;
    else if (VID_REQ)                dec = S_VID;
    else if (cpu_pend || cpu_set)    dec = S_CPU;
    else if (z80_ref_pend || ref_set) dec = S_REF;
    else                             dec = S_IDLE;
    nslot     = last ? dec : slot;
    nwr       = last ? (cpu_set ? WR_n : wr_pend) : slot_wr;
    cpu_start = last && (dec == S_CPU);
    ref_start = last && (dec == S_REF);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      PHASE        <= 3'd0;
      slot         <= S_IDLE;
      slot_wr      <= 1'b1;
      ref_cnt      <= 8'd0;
      cpu_pend     <= 1'b0;
      wr_pend      <= 1'b1;
      arm          <= 1'b1;
      z80_ref_pend <= 1'b0;
      CPU_MISS     <= 1'b0;
      {RAS_n, CAS_n, AMUX, WE_n, VID_LE, CPU_LE, CPU_SLOT, REF_SLOT} <= STROBES_OFF;
    end else begin
      PHASE    <= nphase;
      slot     <= nslot;
      slot_wr  <= nwr;
      {RAS_n, CAS_n, AMUX, WE_n, VID_LE, CPU_LE, CPU_SLOT, REF_SLOT} <= strobes(nslot, nphase, nwr);
      CPU_MISS <= MREQ_n && cpu_pend && !cpu_start;

      if (cpu_start || MREQ_n) cpu_pend <= 1'b0;
      else if (cpu_set)        cpu_pend <= 1'b1;
      if (cpu_set) wr_pend <= WR_n;

      if (cpu_start)   arm <= 1'b0;
      else if (MREQ_n) arm <= 1'b1;

      if (ref_start)    z80_ref_pend <= 1'b0;
      else if (ref_set) z80_ref_pend <= 1'b1;

      if (ref_start)                     ref_cnt <= 8'd0;
      else if (last && ref_cnt != REF_MAX) ref_cnt <= ref_cnt + 8'd1;
    end
  end

endmodule
